io_interrupt_controller: RTL
============================

IO_INTERRUPT_CONTROLLER -- requirements
Module: io_interrupt_controller

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: io_read  in  1  latch register at d_addr[3:0] into read-holding register RDATA.
REQ-004 SHALL have ports: io_write  in  1  write d_bus into register at d_addr[3:0].
REQ-005 SHALL have ports: io_push  in  1  drive RDATA onto d_bus.
REQ-006 SHALL have ports: io_store_retaddr  in  1  capture d_bus into RETADDR; interrupt acknowledge.
REQ-007 SHALL have ports: io_push_retaddr  in  1  drive RETADDR onto d_bus.
REQ-008 SHALL have ports: io_push_ints  in  1  drive {ENABLE[7:0], PENDING[7:0]} onto d_bus.
REQ-009 SHALL have ports: io_push_int_addr  in  1  drive VECTOR onto d_bus.
REQ-010 SHALL have ports: io_interrupt  out  1  interrupt request to the CPU.
REQ-011 SHALL have ports: d_bus  inout  16  shared data bus; Z unless a push strobe is high.
REQ-012 SHALL have ports: d_addr  in  16  register select; only bits [3:0] decoded.
REQ-013 SHALL have ports: irq  in  8  peripheral interrupt lines, index 0 highest priority.
REQ-014 SHALL have ports: gpio_out  out  8  GPOUT register contents.

Function
REQ-015 Register map SHALL be: 0 PENDING (R, write-1-to-clear); 1 ENABLE (RW); 2 VBASE (RW, 16 bit); 3 INSERVICE (R, one-hot); 4 EOI (W, any data); 5 GPOUT (RW); others read 0, writes ignored; 8-bit registers occupy d_bus[7:0], upper bits read 0.
REQ-016 io_read SHALL load RDATA at the edge, so data is valid on d_bus one cycle later under io_push.
REQ-017 Push strobes SHALL drive d_bus combinationally; if several are high, priority SHALL be io_push_int_addr > io_push_ints > io_push_retaddr > io_push.
REQ-018 VECTOR SHALL equal VBASE + 2*n, where n is the in-service index (pending index while in REQ), computed modulo 2^16.
REQ-019 FSM SHALL have states IDLE, REQ, SERVICE.
REQ-020 IDLE->REQ SHALL occur when (PENDING & ENABLE) is nonzero; io_interrupt SHALL be registered high in REQ.
REQ-021 REQ->SERVICE SHALL occur on io_store_retaddr: set INSERVICE bit of the lowest pending-enabled index, clear that PENDING bit, drop io_interrupt next cycle.
REQ-022 REQ->IDLE SHALL occur if (PENDING & ENABLE) becomes zero before acknowledge.
REQ-023 SERVICE->IDLE SHALL occur on an EOI write, clearing INSERVICE; no nesting, and new requests stay pending meanwhile.
REQ-024 A PENDING set event SHALL win over a same-cycle W1C of the same bit.
REQ-025 ENABLE writes SHALL affect request evaluation from the next cycle.
REQ-026 io_store_retaddr outside REQ SHALL only capture RETADDR, with no state change.

Reset
REQ-027 On rst: PENDING, ENABLE, VBASE, INSERVICE, GPOUT, RETADDR, RDATA and edge history SHALL be 0; FSM SHALL be IDLE; io_interrupt SHALL be 0; gpio_out SHALL be 0; d_bus SHALL be Z.
REQ-028 rst in any state, including SERVICE, SHALL abandon the service with no EOI required.

Configuration
REQ-029 With IOC_IRQ_EDGE_EN defined, a PENDING bit SHALL set on a rising edge of irq[n] (previous-cycle compare) and hold until cleared.
REQ-030 Without IOC_IRQ_EDGE_EN, PENDING[n] SHALL be level-sensitive and equal to irq[n] each cycle, and W1C SHALL have no effect.

Verification
REQ-031 Write ENABLE=0x01 and VBASE=0x0100, pulse irq[0] -> io_interrupt=1 within 2 cycles; io_push_int_addr drives 0x0100.
REQ-032 Enable all lines and raise irq[3] and irq[5] together -> acknowledge selects index 3, vector VBASE+6, PENDING=0x20 afterwards.
REQ-033 In SERVICE, raise irq[1] -> io_interrupt stays 0; EOI write -> returns to IDLE, then REQ with vector VBASE+2.
REQ-034 io_read at address 5 after writing GPOUT=0xA5, then io_push -> d_bus=0x00A5; with all strobes low -> d_bus=Z.
REQ-035 Assert rst in SERVICE -> next cycle io_interrupt=0, INSERVICE=0, gpio_out=0.
REQ-036 In edge mode, W1C PENDING bit 2 in the same cycle as an irq[2] rising edge -> PENDING[2]=1.

Source files
------------

// File: rtl/io_interrupt_controller.sv
// Eight-line prioritised interrupt controller with vector generation, retaddr capture and a GPIO register.
// Define IOC_IRQ_EDGE_EN for rising-edge latched PENDING; default build is level-sensitive.
module io_interrupt_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic        io_read,
  input  logic        io_write,
  input  logic        io_push,
  input  logic        io_store_retaddr,
  input  logic        io_push_retaddr,
  input  logic        io_push_ints,
  input  logic        io_push_int_addr,
  output logic        io_interrupt,
  inout  wire logic [15:0] d_bus,
  input  logic [15:0] d_addr,
  input  logic [7:0]  irq,
  output logic [7:0]  gpio_out
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_e;

  state_e      state_q;
  logic [7:0]  pending_q, pending_d;
  logic [7:0]  enable_q, inservice_q, gpout_q;
  logic [15:0] vbase_q, retaddr_q, rdata_q;
  logic        int_q;
  logic [3:0]  addr;
  logic [7:0]  active;
  logic [2:0]  act_idx, svc_idx, vec_idx;
  logic [15:0] vector, rd_val, bus_out;
  logic        bus_en, ack, eoi;
  logic        unused_addr;

  assign addr        = d_addr[3:0];
  assign unused_addr = ^d_addr[15:4];
  assign active      = pending_q & enable_q;
  assign ack         = io_store_retaddr && (state_q == REQ) && (active != '0);
  assign eoi         = io_write && (addr == 4'd4) && (state_q == SERVICE);

  // Scan from the top so the final assignment lands on the lowest set index.
  always_comb begin
    act_idx = '0;
    svc_idx = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (active[7 - i])      act_idx = 3'(7 - i);
      if (inservice_q[7 - i]) svc_idx = 3'(7 - i);
    end
  end

  assign vec_idx = (state_q == SERVICE) ? svc_idx : act_idx;
  assign vector  = vbase_q + {12'd0, vec_idx, 1'b0};

`ifdef IOC_IRQ_EDGE_EN
  logic [7:0] irq_prev_q;

  // Set events are OR-ed in last so they win over a same-cycle W1C or acknowledge.
  always_comb begin
    pending_d = pending_q;
    if (io_write && (addr == 4'd0)) pending_d = pending_d & ~d_bus[7:0];
    if (ack) pending_d[act_idx] = 1'b0;
    pending_d = pending_d | (irq & ~irq_prev_q);
  end

  always_ff @(posedge clk) begin
    if (rst) irq_prev_q <= '0;
    else     irq_prev_q <= irq;
  end
`else
  always_comb begin
    pending_d = irq;
  end
`endif

  always_comb begin
    rd_val = '0;
    case (addr)
      4'd0:    rd_val = {8'h00, pending_q};
      4'd1:    rd_val = {8'h00, enable_q};
      4'd2:    rd_val = vbase_q;
      4'd3:    rd_val = {8'h00, inservice_q};
      4'd5:    rd_val = {8'h00, gpout_q};
      default: rd_val = '0;
    endcase
  end

  always_comb begin
    bus_out = rdata_q;
    if (io_push_int_addr)     bus_out = vector;
    else if (io_push_ints)    bus_out = {enable_q, pending_q};
    else if (io_push_retaddr) bus_out = retaddr_q;
  end

  assign bus_en       = io_push | io_push_retaddr | io_push_ints | io_push_int_addr;
  assign d_bus        = bus_en ? bus_out : 'z;
  assign io_interrupt = int_q;
  assign gpio_out     = gpout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      int_q       <= 1'b0;
      pending_q   <= '0;
      enable_q    <= '0;
      vbase_q     <= '0;
      inservice_q <= '0;
      gpout_q     <= '0;
      retaddr_q   <= '0;
      rdata_q     <= '0;
    end else begin
      pending_q <= pending_d;
      if (io_read)          rdata_q   <= rd_val;
      if (io_store_retaddr) retaddr_q <= d_bus;
      if (io_write) begin
        case (addr)
          4'd1:    enable_q <= d_bus[7:0];
          4'd2:    vbase_q  <= d_bus;
          4'd5:    gpout_q  <= d_bus[7:0];
          default: ;
        endcase
      end
      case (state_q)
        IDLE: begin
          if (active != '0) begin
            state_q <= REQ;
            int_q   <= 1'b1;
          end
        end
        REQ: begin
          if (active == '0) begin
            state_q <= IDLE;
            int_q   <= 1'b0;
          end else if (ack) begin
            state_q     <= SERVICE;
            int_q       <= 1'b0;
            inservice_q <= 8'b1 << act_idx;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state_q     <= IDLE;
            inservice_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          int_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule
